// File: rtl/mtx_mul_pkg.sv
// mtx_mul_pkg: shared types and constants for the matrix-multiply engine.
// Holds the FSM state encoding, the issue-to-result pipeline latency and the
// helpers that size the row/column/chunk index ports.
package mtx_mul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Cycles from a chunk issue to its accumulated value in the result register.
    localparam int PIPE_LAT = 3;

    // Width of a row/column index for a DIM-wide matrix.
    function automatic int idx_w(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

    // Width of the chunk index; one spare bit so NCH=1 still gets a real port.
    function automatic int chunk_w(input int nch);
        return $clog2(nch) + 1;
    endfunction

endpackage

// File: rtl/mtx_mul_engine_if.sv
// mtx_mul_engine_if: operand-fetch and result-stream signals of the engine.
// CYCLE_CNT only exists when MTX_CYCLE_CNT_EN is defined.
//
// Result handshake: RES_VALID is raised by the engine with RES_ROW/RES_COL/
// RES_DATA and held, with all three stable, until a cycle in which RES_READY
// is also high; that cycle transfers exactly one result. RES_READY may be
// driven freely and never combinationally depends on RES_VALID.
interface mtx_mul_engine_if #(
    parameter int DIM    = 8,
    parameter int LANES  = 8,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 2*DATA_W + $clog2(DIM)
);
    localparam int NCH = DIM / LANES;
    localparam int IW  = mtx_mul_pkg::idx_w(DIM);
    localparam int CW  = mtx_mul_pkg::chunk_w(NCH);

    logic                    START;
    logic                    ABORT;
    logic                    SIGNED_MD;
    logic [IW-1:0]           ROW_IDX;
    logic [IW-1:0]           COL_IDX;
    logic [CW-1:0]           CHUNK_IDX;
    logic [LANES*DATA_W-1:0] A_VEC;
    logic [LANES*DATA_W-1:0] B_VEC;
    logic                    RES_VALID;
    logic                    RES_READY;
    logic [IW-1:0]           RES_ROW;
    logic [IW-1:0]           RES_COL;
    logic [ACC_W-1:0]        RES_DATA;
    logic                    BUSY;
    logic                    DONE;
`ifdef MTX_CYCLE_CNT_EN
    logic [63:0]             CYCLE_CNT;
`endif
    mtx_mul_pkg::state_t     dbg_state;

    modport master (
        input  START, ABORT, SIGNED_MD, A_VEC, B_VEC, RES_READY,
        output ROW_IDX, COL_IDX, CHUNK_IDX, RES_VALID, RES_ROW, RES_COL,
        output RES_DATA, BUSY, DONE, dbg_state
`ifdef MTX_CYCLE_CNT_EN
        , output CYCLE_CNT
`endif
    );

    modport slave (
        output START, ABORT, SIGNED_MD, A_VEC, B_VEC, RES_READY,
        input  ROW_IDX, COL_IDX, CHUNK_IDX, RES_VALID, RES_ROW, RES_COL,
        input  RES_DATA, BUSY, DONE, dbg_state
`ifdef MTX_CYCLE_CNT_EN
        , input CYCLE_CNT
`endif
    );

endinterface

// File: rtl/mtx_dot_lanes.sv
// mtx_dot_lanes: LANES parallel multipliers (stage 1) feeding a registered
// adder tree (stage 2). Operands are sign- or zero-extended by one bit so a
// single signed multiplier covers both modes. Everything holds while en=0.
module mtx_dot_lanes #(
    parameter int LANES  = 8,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 67
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    signed_md,
    input  logic [LANES*DATA_W-1:0] a_vec,
    input  logic [LANES*DATA_W-1:0] b_vec,
    output logic [ACC_W-1:0]        sum
);
    localparam int PW = 2*DATA_W + 2;

    logic [ACC_W-1:0] prod_d [LANES];
    logic [ACC_W-1:0] prod_q [LANES];
    logic [ACC_W-1:0] sum_d;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [DATA_W:0] a_x;
        logic signed [DATA_W:0] b_x;
        logic signed [PW-1:0]   p_x;
        assign a_x = {signed_md & a_vec[l*DATA_W + DATA_W - 1], a_vec[l*DATA_W +: DATA_W]};
        assign b_x = {signed_md & b_vec[l*DATA_W + DATA_W - 1], b_vec[l*DATA_W +: DATA_W]};
        assign p_x = PW'(a_x) * PW'(b_x);
        // Sign-extend or wrap the exact product into the accumulator width.
        assign prod_d[l] = ACC_W'(p_x);
    end

    // Stage 1: register the lane products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) prod_q[l] <= '0;
        end else if (en) begin
            for (int l = 0; l < LANES; l++) prod_q[l] <= prod_d[l];
        end
    end

    // Sum the registered products (modulo 2^ACC_W).
    always_comb begin
        sum_d = '0;
        for (int l = 0; l < LANES; l++) sum_d = sum_d + prod_q[l];
    end

    // Stage 2: register the chunk sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  sum <= '0;
        else if (en) sum <= sum_d;
    end

endmodule

// File: rtl/mtx_mul_engine.sv
// mtx_mul_engine: C = A x B for DIM x DIM matrices. Issues one LANES-wide
// chunk per cycle (chunk innermost, then column, then row), accumulates the
// NCH chunk sums of each element and streams results row-major.
// Optional feature: define MTX_CYCLE_CNT_EN to add the 64-bit CYCLE_CNT output.
module mtx_mul_engine
    import mtx_mul_pkg::*;
#(
    parameter int DIM    = 8,
    parameter int LANES  = 8,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 2*DATA_W + $clog2(DIM)
) (
    input logic              ACLK,
    input logic              ARESETN,
    mtx_mul_engine_if.master bus
);
    localparam int NCH = DIM / LANES;
    localparam int IW  = idx_w(DIM);
    localparam int CW  = chunk_w(NCH);

    // Side-band travelling alongside the data through stages 1 and 2.
    typedef struct packed {
        logic          v;
        logic          first;
        logic          last;
        logic [IW-1:0] row;
        logic [IW-1:0] col;
    } tag_t;

    state_t           state_q, state_d;
    logic             en, start_acc, abort_act, issue, last_beat, final_accept;
    logic             signed_q, pipe_busy;
    logic [IW-1:0]    row_q, col_q;
    logic [CW-1:0]    chunk_q;
    tag_t             tag_in;
    tag_t             tag_q [PIPE_LAT-1];
    tag_t             tag_out;
    logic [ACC_W-1:0] dot_sum, acc_q;
    logic             res_valid_q;
    logic [IW-1:0]    res_row_q, res_col_q;

    // A stalled result freezes the whole pipeline, including the issue counters.
    assign en           = !res_valid_q || bus.RES_READY;
    assign abort_act    = bus.ABORT && (state_q != IDLE);
    assign start_acc    = bus.START && !bus.ABORT && (state_q == IDLE);
    assign issue        = (state_q == RUN) && en;
    assign last_beat    = (row_q == IW'(DIM-1)) && (col_q == IW'(DIM-1)) && (chunk_q == CW'(NCH-1));
    assign tag_out      = tag_q[PIPE_LAT-2];
    assign final_accept = (state_q == DRAIN) && res_valid_q && bus.RES_READY && !pipe_busy;

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; ABORT overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (abort_act) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_acc) state_d = RUN;
                RUN:     if (issue && last_beat) state_d = DRAIN;
                DRAIN:   if (final_accept) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State-decoded outputs.
    always_comb begin
        bus.BUSY      = (state_q != IDLE);
        bus.DONE      = (state_q == DONE);
        bus.dbg_state = state_q;
    end

    // Operand signedness is captured once per job.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)       signed_q <= 1'b0;
        else if (start_acc) signed_q <= bus.SIGNED_MD;
    end

    // Issue counters: hold on the last beat through DRAIN, zero whenever heading to IDLE.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            row_q   <= '0;
            col_q   <= '0;
            chunk_q <= '0;
        end else if (abort_act || state_q == IDLE || state_q == DONE) begin
            row_q   <= '0;
            col_q   <= '0;
            chunk_q <= '0;
        end else if (issue && !last_beat) begin
            if (chunk_q == CW'(NCH-1)) begin
                chunk_q <= '0;
                if (col_q == IW'(DIM-1)) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end else begin
                chunk_q <= chunk_q + 1'b1;
            end
        end
    end

    assign bus.ROW_IDX   = row_q;
    assign bus.COL_IDX   = col_q;
    assign bus.CHUNK_IDX = chunk_q;

    always_comb begin
        tag_in.v     = issue;
        tag_in.first = (chunk_q == '0);
        tag_in.last  = (chunk_q == CW'(NCH-1));
        tag_in.row   = row_q;
        tag_in.col   = col_q;
    end

    // Tag pipeline matching the two data stages of the dot-product unit.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int k = 0; k < PIPE_LAT-1; k++) tag_q[k] <= '0;
        end else if (abort_act) begin
            for (int k = 0; k < PIPE_LAT-1; k++) tag_q[k].v <= 1'b0;
        end else if (en) begin
            tag_q[0] <= tag_in;
            for (int k = 1; k < PIPE_LAT-1; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    // Any chunk still in flight ahead of the result register.
    always_comb begin
        pipe_busy = 1'b0;
        for (int k = 0; k < PIPE_LAT-1; k++) pipe_busy = pipe_busy | tag_q[k].v;
    end

    mtx_dot_lanes #(
        .LANES (LANES),
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_dot (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .en       (en),
        .signed_md(signed_q),
        .a_vec    (bus.A_VEC),
        .b_vec    (bus.B_VEC),
        .sum      (dot_sum)
    );

    // Stage 3: first chunk loads the accumulator, later chunks add; the last raises RES_VALID.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            res_valid_q <= 1'b0;
            acc_q       <= '0;
            res_row_q   <= '0;
            res_col_q   <= '0;
        end else if (abort_act) begin
            res_valid_q <= 1'b0;
        end else if (en) begin
            res_valid_q <= tag_out.v && tag_out.last;
            if (tag_out.v) begin
                acc_q     <= tag_out.first ? dot_sum : acc_q + dot_sum;
                res_row_q <= tag_out.row;
                res_col_q <= tag_out.col;
            end
        end
    end

    assign bus.RES_VALID = res_valid_q;
    assign bus.RES_DATA  = acc_q;
    assign bus.RES_ROW   = res_row_q;
    assign bus.RES_COL   = res_col_q;

`ifdef MTX_CYCLE_CNT_EN
    logic [63:0] cyc_cnt_q;

    // Job cycle counter: restarts on an accepted START, saturates, frozen once idle.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)                                  cyc_cnt_q <= '0;
        else if (start_acc)                            cyc_cnt_q <= '0;
        else if (state_q != IDLE && cyc_cnt_q != '1)   cyc_cnt_q <= cyc_cnt_q + 64'd1;
    end

    assign bus.CYCLE_CNT = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_mtx_mul_engine.sv
// tb_mtx_mul_engine: table-driven directed bench for mtx_mul_engine with
// DIM=4, LANES=2, DATA_W=8 (two chunks per element, 18-bit results).
module tb_mtx_mul_engine;
    localparam int DIM    = 4;
    localparam int LANES  = 2;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 2*DATA_W + $clog2(DIM);

    typedef struct {
        string name;
        int    a_kind;
        int    b_kind;
        bit    sgn;
        int    exp_kind;
        int    stall_at;
        int    abort_at;
        int    restart_at;
        int    n_exp;
        int    done_at;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mtx_mul_engine_if #(.DIM(DIM), .LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    mtx_mul_engine #(.DIM(DIM), .LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .ACLK   (clk),
        .ARESETN(rst_n),
        .bus    (bus)
    );

    // ---------------- operand register file model ----------------
    logic [DATA_W-1:0] mem_a [DIM][DIM];
    logic [DATA_W-1:0] mem_b [DIM][DIM];

    always_comb begin
        bus.A_VEC = '0;
        bus.B_VEC = '0;
        for (int l = 0; l < LANES; l++) begin
            bus.A_VEC[l*DATA_W +: DATA_W] = mem_a[bus.ROW_IDX][int'(bus.CHUNK_IDX)*LANES + l];
            bus.B_VEC[l*DATA_W +: DATA_W] = mem_b[int'(bus.CHUNK_IDX)*LANES + l][bus.COL_IDX];
        end
    end

    // ---------------- scoreboard ----------------
    logic [ACC_W-1:0] exp_q[$];
    int               exp_rc_q[$];
    int               n_tests = 0;
    int               n_fail  = 0;
    vec_t             vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // A kinds: 0 identity, 1 all 0xFF, 2 diag(1,2,3,4), 3 all 2, 4 diag(0xFF)
    function automatic logic [DATA_W-1:0] a_val(input int kind, input int i, input int k);
        case (kind)
            0:       return (i == k) ? 8'd1 : 8'd0;
            1:       return 8'hFF;
            2:       return (i == k) ? 8'(i + 1) : 8'd0;
            3:       return 8'd2;
            default: return (i == k) ? 8'hFF : 8'd0;
        endcase
    endfunction

    // B kinds: 0 B[k][j]=4k+j, 1 all 0xFF, 2 identity
    function automatic logic [DATA_W-1:0] b_val(input int kind, input int k, input int j);
        case (kind)
            0:       return 8'(4*k + j);
            1:       return 8'hFF;
            default: return (k == j) ? 8'd1 : 8'd0;
        endcase
    endfunction

    // Hand-derived closed forms of C for each table row.
    function automatic logic [ACC_W-1:0] exp_val(input int kind, input int i, input int j);
        case (kind)
            0:       return ACC_W'(4*i + j);            // I x B = B
            1:       return ACC_W'(4);                  // (-1)(-1) summed 4 times
            2:       return ACC_W'(260100);             // 4*255*255
            3:       return ACC_W'((i + 1) * (4*i + j)); // diag row scaling
            4:       return ACC_W'(2);                  // all-2 x I
            default: return ACC_W'(-(4*i + j));         // -I x B, wrapped to 18 bits
        endcase
    endfunction

    // ---------------- driver: one complete job ----------------
    task automatic run_job(input vec_t v);
        int cyc        = 0;
        int n_res      = 0;
        int stall_left = 0;
        int n_done     = 0;
        int done_cyc   = -1;
        bit stalled    = 1'b0;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                mem_a[i][j] = a_val(v.a_kind, i, j);
                mem_b[i][j] = b_val(v.b_kind, i, j);
            end
        exp_q.delete();
        exp_rc_q.delete();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                exp_q.push_back(exp_val(v.exp_kind, i, j));
                exp_rc_q.push_back(i*DIM + j);
            end

        @(negedge clk);
        bus.START     = 1'b1;
        bus.SIGNED_MD = v.sgn;
        bus.ABORT     = 1'b0;
        bus.RES_READY = 1'b1;
        @(negedge clk);
        bus.START     = 1'b0;
        bus.SIGNED_MD = !v.sgn;   // must not affect the job in flight
        cyc = 1;
        check({v.name, "_busy_c1"}, bus.BUSY, 1);
        check({v.name, "_idx_c1"}, {bus.ROW_IDX, bus.COL_IDX, bus.CHUNK_IDX}, 0);

        while (cyc < 120) begin
            bus.START = (cyc == v.restart_at);
            bus.ABORT = (cyc == v.abort_at);
            if (!stalled && bus.RES_VALID && n_res == v.stall_at) begin
                stalled    = 1'b1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                bus.RES_READY = 1'b0;
                stall_left--;
                check({v.name, "_stall_valid"}, bus.RES_VALID, 1);
                if (exp_q.size() > 0) check({v.name, "_stall_data"}, bus.RES_DATA, exp_q[0]);
                // Third result (C[0][2]) appears in cycle 9 while beat row1/col0/chunk0 is being fetched.
                check({v.name, "_stall_row"}, bus.ROW_IDX, 1);
                check({v.name, "_stall_col"}, bus.COL_IDX, 0);
                check({v.name, "_stall_chunk"}, bus.CHUNK_IDX, 0);
            end else begin
                bus.RES_READY = 1'b1;
            end
            if (v.abort_at > 0 && cyc == v.abort_at + 1) begin
                check({v.name, "_abort_busy"}, bus.BUSY, 0);
                check({v.name, "_abort_valid"}, bus.RES_VALID, 0);
            end
            if (bus.DONE) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (bus.RES_VALID && bus.RES_READY) begin
                if (exp_q.size() > 0) begin
                    check({v.name, "_data"}, bus.RES_DATA, exp_q.pop_front());
                    check({v.name, "_rowcol"}, int'(bus.RES_ROW)*DIM + int'(bus.RES_COL), exp_rc_q.pop_front());
                end
                n_res++;
            end
            if (done_cyc > 0 && cyc == done_cyc + 1) begin
                check({v.name, "_idle_after_done"}, bus.BUSY, 0);
                break;
            end
            if (v.abort_at > 0 && cyc == v.abort_at + 25) break;
            @(negedge clk);
            cyc++;
        end
        bus.START     = 1'b0;
        bus.ABORT     = 1'b0;
        bus.RES_READY = 1'b1;
        check({v.name, "_n_results"}, n_res, v.n_exp);
        check({v.name, "_done_cycle"}, done_cyc, v.done_at);
        check({v.name, "_done_count"}, n_done, (v.done_at >= 0) ? 1 : 0);
`ifdef MTX_CYCLE_CNT_EN
        check({v.name, "_cycle_cnt"}, bus.CYCLE_CNT, (v.done_at >= 0) ? v.done_at : v.abort_at);
`endif
        repeat (2) @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        //          name                a  b  sgn exp stall abort restart n  done
        vecs[0] = '{"identity",         0, 0, 0,  0,  -1,   -1,   -1,     16, 36};
        vecs[1] = '{"neg1_signed",      1, 1, 1,  1,  -1,   -1,   -1,     16, 36};
        vecs[2] = '{"ff_unsigned",      1, 1, 0,  2,  -1,   -1,   -1,     16, 36};
        vecs[3] = '{"diag_scale",       2, 0, 0,  3,  -1,   -1,   -1,     16, 36};
        vecs[4] = '{"neg_eye_signed",   4, 0, 1,  5,  -1,   -1,   -1,     16, 36};
        vecs[5] = '{"twos_eye",         3, 2, 1,  4,  -1,   -1,   -1,     16, 36};
        vecs[6] = '{"stall5",           0, 0, 0,  0,   2,   -1,   -1,     16, 41};
        vecs[7] = '{"abort10",          0, 0, 0,  0,  -1,   10,   -1,      3, -1};
        vecs[8] = '{"after_abort",      0, 0, 0,  0,  -1,   -1,   -1,     16, 36};
        vecs[9] = '{"restart_ignored",  0, 0, 0,  0,  -1,   -1,    5,     16, 36};

        bus.START     = 1'b0;
        bus.ABORT     = 1'b0;
        bus.SIGNED_MD = 1'b0;
        bus.RES_READY = 1'b1;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                mem_a[i][j] = '0;
                mem_b[i][j] = '0;
            end

        repeat (3) @(negedge clk);
        check("rst_busy", bus.BUSY, 0);
        check("rst_done", bus.DONE, 0);
        check("rst_valid", bus.RES_VALID, 0);
        check("rst_data", bus.RES_DATA, 0);
        check("rst_idx", {bus.ROW_IDX, bus.COL_IDX, bus.CHUNK_IDX}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 10; n++) run_job(vecs[n]);

        // Reset asserted while draining: outputs clear at once, engine idles after release.
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                mem_a[i][j] = a_val(0, i, j);
                mem_b[i][j] = b_val(0, i, j);
            end
        @(negedge clk);
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (33) @(negedge clk);   // now in cycle 34, DRAIN
        check("drain_busy", bus.BUSY, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.BUSY, 0);
        check("arst_valid", bus.RES_VALID, 0);
        check("arst_data", bus.RES_DATA, 0);
        check("arst_rowcol", {bus.RES_ROW, bus.RES_COL}, 0);
        check("arst_idx", {bus.ROW_IDX, bus.COL_IDX, bus.CHUNK_IDX}, 0);
`ifdef MTX_CYCLE_CNT_EN
        check("arst_cnt", bus.CYCLE_CNT, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", bus.BUSY, 0);
        check("post_rst_done", bus.DONE, 0);

        run_job(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
